// File: rtl/port_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : port_pkt_buffer
// Brief    : Per-port packet buffer; stores committed packets, replays one
//            whole packet on m_axis per dequeue request.
// Revision : 1.0 - initial release
// ============================================================================
module port_pkt_buffer #(
    parameter int DATA_WIDTH    = 256,
    parameter int TUSER_WIDTH   = 128,
    parameter int DEPTH_LOG2    = 9,
    parameter int AF_MARGIN     = 64,
    parameter int PKT_CNT_WIDTH = 10
) (
    input  logic                     axis_aclk,
    input  logic                     axis_resetn,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_wr_en,
    output logic                     m_axis_buffer_almost_full,
    input  logic                     s_deq_req,
    output logic                     m_deq_ready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [PKT_CNT_WIDTH-1:0] m_pkt_cnt,
    output logic [31:0]              m_drop_cnt
);

    localparam int              c_kw        = DATA_WIDTH / 8;
    localparam int              c_pw        = DEPTH_LOG2 + 1;
    localparam int              c_mw        = DATA_WIDTH + c_kw + TUSER_WIDTH + 1;
    localparam logic [c_pw-1:0] c_depth     = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [31:0]     c_af_margin = AF_MARGIN;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    logic [c_mw-1:0]          r_mem [0:(1<<DEPTH_LOG2)-1];

    logic [c_pw-1:0]          r_wr_ptr;
    logic [c_pw-1:0]          r_commit_ptr;
    logic [c_pw-1:0]          r_rd_ptr;
    logic                     r_drop;
    logic [31:0]              r_drop_cnt;
    logic [PKT_CNT_WIDTH-1:0] r_pkt_cnt;
    logic                     r_af;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_prime;
    logic                     r_fetch_done;
    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_out_data;
    logic [c_kw-1:0]          r_out_keep;
    logic [TUSER_WIDTH-1:0]   r_out_user;
    logic                     r_out_last;

    logic                     w_wr_beat;
    logic                     w_full;
    logic                     w_discard;
    logic                     w_commit;
    logic                     w_accept;
    logic                     w_fetch;
    logic                     w_out_fire;
    logic [c_pw-1:0]          w_wr_ptr_inc;
    logic [c_pw-1:0]          w_used;
    logic [c_pw-1:0]          w_free;
    logic [c_mw-1:0]          w_rd_word;

    assign w_wr_beat    = s_axis_tvalid & s_axis_wr_en;
    assign w_full       = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                          (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_discard    = w_wr_beat & (r_drop | w_full);
    assign w_commit     = w_wr_beat & ~w_discard & s_axis_tlast;
    assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
    assign w_used       = r_wr_ptr - r_rd_ptr;
    assign w_free       = c_depth - w_used;

    assign m_deq_ready  = (r_state == ST_IDLE) && (r_pkt_cnt != '0);
    assign w_accept     = s_deq_req & m_deq_ready;
    assign w_out_fire   = r_out_valid & m_axis_tready;
    // The prime cycle after acceptance gives the two-edge request-to-data latency.
    assign w_fetch      = (r_state == ST_SEND) & ~r_prime & ~r_fetch_done &
                          (~r_out_valid | m_axis_tready);
    assign w_rd_word    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge axis_aclk) begin
        if (axis_resetn && w_wr_beat && !w_discard) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tdata, s_axis_tkeep,
                                                s_axis_tuser, s_axis_tlast};
        end
    end

    // Write pointer, commit point and overflow drop handling.
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_drop       <= 1'b0;
            r_drop_cnt   <= '0;
        end else if (w_wr_beat) begin
            if (w_discard) begin
                r_wr_ptr <= r_commit_ptr;
                r_drop   <= ~s_axis_tlast;
                if (s_axis_tlast && (r_drop_cnt != 32'hFFFF_FFFF)) begin
                    r_drop_cnt <= r_drop_cnt + 32'd1;
                end
            end else begin
                r_wr_ptr <= w_wr_ptr_inc;
                if (s_axis_tlast) begin
                    r_commit_ptr <= w_wr_ptr_inc;
                end
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_pkt_cnt <= '0;
            r_af      <= 1'b0;
        end else begin
            case ({w_commit, w_accept})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
            r_af <= ({{(32-c_pw){1'b0}}, w_free} <= c_af_margin);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_SEND;
            ST_SEND: if (w_out_fire && r_out_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            r_state      <= ST_IDLE;
            r_prime      <= 1'b0;
            r_fetch_done <= 1'b0;
            r_rd_ptr     <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_user   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prime <= w_accept;
            if (w_accept) begin
                r_fetch_done <= 1'b0;
            end
            if (w_fetch) begin
                {r_out_data, r_out_keep, r_out_user, r_out_last} <= w_rd_word;
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                if (w_rd_word[0]) begin
                    r_fetch_done <= 1'b1;
                end
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign m_axis_buffer_almost_full = r_af;
    assign m_pkt_cnt                 = r_pkt_cnt;
    assign m_drop_cnt                = r_drop_cnt;
    assign m_axis_tvalid             = r_out_valid;
    assign m_axis_tdata              = r_out_data;
    assign m_axis_tkeep              = r_out_keep;
    assign m_axis_tuser              = r_out_user;
    assign m_axis_tlast              = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_port_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_pkt_buffer
// Brief    : Directed self-checking bench for port_pkt_buffer (scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_port_pkt_buffer;

    localparam int DW  = 64;
    localparam int KW  = DW / 8;
    localparam int UW  = 16;
    localparam int DL  = 4;
    localparam int AFM = 4;
    localparam int PCW = 10;
    localparam int BW  = DW + KW + UW + 1;

    logic           clk = 1'b0;
    logic           axis_resetn;
    logic [DW-1:0]  s_axis_tdata;
    logic [KW-1:0]  s_axis_tkeep;
    logic [UW-1:0]  s_axis_tuser;
    logic           s_axis_tlast;
    logic           s_axis_tvalid;
    logic           s_axis_wr_en;
    logic           m_axis_buffer_almost_full;
    logic           s_deq_req;
    logic           m_deq_ready;
    logic [DW-1:0]  m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic [UW-1:0]  m_axis_tuser;
    logic           m_axis_tlast;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic [PCW-1:0] m_pkt_cnt;
    logic [31:0]    m_drop_cnt;

    logic [BW-1:0]  sb [$];
    int             total = 0;
    int             bad   = 0;

    always #5 clk = ~clk;

    port_pkt_buffer #(
        .DATA_WIDTH   (DW),
        .TUSER_WIDTH  (UW),
        .DEPTH_LOG2   (DL),
        .AF_MARGIN    (AFM),
        .PKT_CNT_WIDTH(PCW)
    ) dut (
        .axis_aclk                (clk),
        .axis_resetn              (axis_resetn),
        .s_axis_tdata             (s_axis_tdata),
        .s_axis_tkeep             (s_axis_tkeep),
        .s_axis_tuser             (s_axis_tuser),
        .s_axis_tlast             (s_axis_tlast),
        .s_axis_tvalid            (s_axis_tvalid),
        .s_axis_wr_en             (s_axis_wr_en),
        .m_axis_buffer_almost_full(m_axis_buffer_almost_full),
        .s_deq_req                (s_deq_req),
        .m_deq_ready              (m_deq_ready),
        .m_axis_tdata             (m_axis_tdata),
        .m_axis_tkeep             (m_axis_tkeep),
        .m_axis_tuser             (m_axis_tuser),
        .m_axis_tlast             (m_axis_tlast),
        .m_axis_tvalid            (m_axis_tvalid),
        .m_axis_tready            (m_axis_tready),
        .m_pkt_cnt                (m_pkt_cnt),
        .m_drop_cnt               (m_drop_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk_beat(input int seed, input int i, input int n);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        d = {32'(seed), 32'(i)};
        k = 8'(i * 37 + seed) | 8'h01;
        u = 16'(seed * 256 + i);
        return {d, k, u, (i == n - 1)};
    endfunction

    // Inputs change on the falling edge; the DUT samples them on the next rising edge.
    task automatic wr_pkt(input int n, input int seed, input bit en, input bit store);
        logic [BW-1:0] b;
        for (int i = 0; i < n; i++) begin
            b = mk_beat(seed, i, n);
            {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = b;
            s_axis_tvalid = 1'b1;
            s_axis_wr_en  = en;
            if (store) sb.push_back(b);
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_wr_en  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic deq_pkt(input int n, input bit toggle);
        int            got;
        bit            stall;
        logic [BW-1:0] cur;
        logic [BW-1:0] held;
        logic [BW-1:0] exp;
        s_deq_req = 1'b1;
        @(negedge clk);
        s_deq_req = 1'b0;
        chk("deq_ready_busy", m_deq_ready, 1'b0);
        chk("lat0_valid", m_axis_tvalid, 1'b0);
        @(negedge clk);
        chk("lat1_valid", m_axis_tvalid, 1'b0);
        @(negedge clk);
        chk("lat2_valid", m_axis_tvalid, 1'b1);
        got   = 0;
        stall = 1'b0;
        held  = '0;
        for (int k = 0; k < 400 && got < n; k++) begin
            m_axis_tready = toggle ? (k % 2 == 0) : 1'b1;
            cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
            if (stall) begin
                chk("hold_valid", m_axis_tvalid, 1'b1);
                chk("hold_data", cur, held);
            end
            stall = m_axis_tvalid && !m_axis_tready;
            held  = cur;
            if (m_axis_tvalid && m_axis_tready) begin
                chk("sb_nonempty", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk("beat", cur, exp);
                end
                got++;
            end
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
        chk("deq_beats", got, n);
        chk("post_valid", m_axis_tvalid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_resetn   = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_wr_en  = 1'b0;
        s_deq_req     = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", m_axis_tvalid, 1'b0);
        chk("rst_ready", m_deq_ready, 1'b0);
        chk("rst_af", m_axis_buffer_almost_full, 1'b0);
        chk("rst_pkt_cnt", m_pkt_cnt, 0);
        chk("rst_drop_cnt", m_drop_cnt, 0);
        chk("rst_data", m_axis_tdata, 0);
        axis_resetn = 1'b1;
        @(negedge clk);

        // 1) basic 3-beat round trip
        wr_pkt(3, 1, 1'b1, 1'b1);
        chk("t1_pkt_cnt_1", m_pkt_cnt, 1);
        chk("t1_deq_ready", m_deq_ready, 1'b1);
        deq_pkt(3, 1'b0);
        chk("t1_pkt_cnt_0", m_pkt_cnt, 0);

        // 2) write with wr_en low stores nothing; request ignored
        wr_pkt(3, 2, 1'b0, 1'b0);
        chk("t2_pkt_cnt", m_pkt_cnt, 0);
        chk("t2_deq_ready", m_deq_ready, 1'b0);
        s_deq_req = 1'b1;
        @(negedge clk);
        s_deq_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_no_valid", m_axis_tvalid, 1'b0);
            @(negedge clk);
        end
        chk("t2_pkt_cnt_end", m_pkt_cnt, 0);

        // 3) almost_full threshold with one-cycle lag
        wr_pkt(12, 3, 1'b1, 1'b1);
        chk("t3_af_lag", m_axis_buffer_almost_full, 1'b0);
        @(negedge clk);
        chk("t3_af_set", m_axis_buffer_almost_full, 1'b1);
        deq_pkt(12, 1'b0);
        @(negedge clk);
        chk("t3_af_clear", m_axis_buffer_almost_full, 1'b0);

        // 4) overflow drop, then 1-beat drop on a full buffer
        wr_pkt(14, 4, 1'b1, 1'b1);
        chk("t4_pkt_cnt_a", m_pkt_cnt, 1);
        chk("t4_af", m_axis_buffer_almost_full, 1'b1);
        wr_pkt(4, 5, 1'b1, 1'b0);
        chk("t4_drop_1", m_drop_cnt, 1);
        chk("t4_pkt_cnt_b", m_pkt_cnt, 1);
        wr_pkt(2, 6, 1'b1, 1'b1);
        chk("t4_pkt_cnt_c", m_pkt_cnt, 2);
        wr_pkt(1, 7, 1'b1, 1'b0);
        chk("t4_drop_2", m_drop_cnt, 2);
        chk("t4_pkt_cnt_d", m_pkt_cnt, 2);
        deq_pkt(14, 1'b0);
        deq_pkt(2, 1'b0);
        chk("t4_pkt_cnt_e", m_pkt_cnt, 0);

        // 5) tready toggling 1010 during a 5-beat dequeue
        wr_pkt(5, 8, 1'b1, 1'b1);
        deq_pkt(5, 1'b1);
        chk("t5_sb_empty", sb.size(), 0);

        // 6) reset during a write and a stalled read
        wr_pkt(3, 60, 1'b1, 1'b1);
        s_deq_req = 1'b1;
        {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = mk_beat(61, 0, 4);
        s_axis_tvalid = 1'b1;
        s_axis_wr_en  = 1'b1;
        @(negedge clk);
        s_deq_req = 1'b0;
        {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = mk_beat(61, 1, 4);
        @(negedge clk);
        {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = mk_beat(61, 2, 4);
        m_axis_tready = 1'b0;
        @(negedge clk);
        chk("t6_mid_read_valid", m_axis_tvalid, 1'b1);
        axis_resetn   = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_wr_en  = 1'b0;
        @(negedge clk);
        chk("t6_valid", m_axis_tvalid, 1'b0);
        chk("t6_ready", m_deq_ready, 1'b0);
        chk("t6_af", m_axis_buffer_almost_full, 1'b0);
        chk("t6_pkt_cnt", m_pkt_cnt, 0);
        chk("t6_drop_cnt", m_drop_cnt, 0);
        chk("t6_data", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, 0);
        axis_resetn   = 1'b1;
        m_axis_tready = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_replay", m_axis_tvalid, 1'b0);
        end
        chk("t6_ready_after", m_deq_ready, 1'b0);
        wr_pkt(2, 70, 1'b1, 1'b1);
        chk("t6_pkt_cnt_new", m_pkt_cnt, 1);
        deq_pkt(2, 1'b0);
        chk("t6_pkt_cnt_end", m_pkt_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
